// File: rtl/feistel_cipher_engine_if.sv
// Handshake bundle for the Feistel engine: block input channel and result channel.
interface feistel_cipher_engine_if #(
  parameter int HALF_W = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   in_data;
  logic [2*HALF_W-1:0]   in_key;
  logic                  in_decrypt;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*HALF_W-1:0]   out_data;

  // Source/sink side of the engine
  modport master (
    output in_valid, in_data, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/feistel_cipher_engine.sv
// Iterative Feistel encrypt/decrypt engine: one round per clock, final half swap
// so that decrypting with the reversed key schedule inverts encryption.
module feistel_cipher_engine #(
  parameter int HALF_W = 4,
  parameter int ROUNDS = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_ni,
  feistel_cipher_engine_if.slave  bus,
  output logic                    busy_o
);
  localparam int BW = 2 * HALF_W;
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [HALF_W-1:0]   l_q, r_q;
  logic [HALF_W-1:0]   l_d, r_d;
  logic [BW-1:0]       key_q;
  logic [BW-1:0]       out_data_q;
  logic [CW-1:0]       cnt_q;
  logic                dec_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                accept;

  logic [CW-1:0]       kidx;
  int unsigned         rot;
  logic [BW-1:0]       rkey;
  logic [HALF_W-1:0]   rev;
  logic [BW-1:0]       e_r;
  logic [BW-1:0]       x;
  logic [HALF_W-1:0]   f;

  // A new block can enter when idle, or when the held result leaves on this same edge
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy_o        = busy_q;

  // Round datapath: key schedule, expansion, mix, carry-discarding add
  always_comb begin
    kidx = dec_q ? (LAST - cnt_q) : cnt_q;
    rot  = 32'(kidx) % BW;
    // rot == 0 shifts the right-hand term fully out, leaving key_q unchanged
    rkey = (key_q << rot) | (key_q >> (BW - rot));
    rev  = '0;
    for (int b = 0; b < HALF_W; b++) rev[HALF_W-1-b] = r_q[b];
    e_r  = {r_q[HALF_W-2:0], r_q[HALF_W-1], rev};
    x    = e_r ^ rkey;
    f    = x[BW-1:HALF_W] + x[HALF_W-1:0] + {{(HALF_W-1){1'b0}}, rkey[0]};
    l_d  = r_q;
    r_d  = l_q ^ f;
  end

  // Control FSM with registered outputs; the last round writes the swapped result directly
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            l_q     <= bus.in_data[BW-1:HALF_W];
            r_q     <= bus.in_data[HALF_W-1:0];
            key_q   <= bus.in_key;
            dec_q   <= bus.in_decrypt;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          l_q   <= l_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_data_q  <= {r_d, l_d};
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              l_q     <= bus.in_data[BW-1:HALF_W];
              r_q     <= bus.in_data[HALF_W-1:0];
              key_q   <= bus.in_key;
              dec_q   <= bus.in_decrypt;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feistel_cipher_engine.sv
// Bench: a 1-round instance pinned with literal vectors, and a 4-round instance
// checked every cycle against a behavioural Feistel model through a scoreboard.
module tb_feistel_cipher_engine;
  localparam int HW = 4;
  localparam int BW = 2 * HW;
  localparam int R4 = 4;

  logic clock;
  logic reset_n;
  logic busy1, busy4;
  int   cyc;
  int   n_cmp, n_bad;

  feistel_cipher_engine_if #(.HALF_W(HW)) i1 ();
  feistel_cipher_engine_if #(.HALF_W(HW)) i4 ();

  feistel_cipher_engine #(.HALF_W(HW), .ROUNDS(1)) dut1 (
    .clock_i(clock), .reset_ni(reset_n), .bus(i1), .busy_o(busy1));
  feistel_cipher_engine #(.HALF_W(HW), .ROUNDS(R4)) dut4 (
    .clock_i(clock), .reset_ni(reset_n), .bus(i4), .busy_o(busy4));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Straight-from-the-rules Feistel model on integers
  function automatic logic [BW-1:0] model(input logic [BW-1:0] d, input logic [BW-1:0] k,
                                          input bit dec, input int rounds);
    int l, r, kv, ki, s, kk, rv, e, x, f, t;
    int m, km;
    m  = (1 << HW) - 1;
    km = (1 << BW) - 1;
    l  = int'(d[BW-1:HW]);
    r  = int'(d[HW-1:0]);
    kv = int'(k);
    for (int i = 0; i < rounds; i++) begin
      ki = dec ? (rounds - 1 - i) : i;
      s  = ki % BW;
      kk = ((kv << s) | (kv >> (BW - s))) & km;
      rv = 0;
      for (int b = 0; b < HW; b++) if (((r >> b) & 1) == 1) rv |= 1 << (HW - 1 - b);
      e  = ((((r << 1) | (r >> (HW - 1))) & m) << HW) | rv;
      x  = e ^ kk;
      f  = ((x >> HW) + (x & m) + (kk & 1)) & m;
      t  = r;
      r  = l ^ f;
      l  = t;
    end
    return BW'((r << HW) | l);
  endfunction

  // Scoreboard for the 4-round instance
  logic [BW-1:0] exp_q[$];
  int            acc_q[$];
  bit            seen;

  // Per-cycle compare: data, latency, hold under backpressure, busy, and new accepts
  always @(negedge clock) begin
    if (reset_n) begin
      chk("busy4", busy4, (exp_q.size() != 0) && !i4.out_valid);
      if (i4.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", i4.out_valid, 0);
        else begin
          if (!seen) begin
            chk("latency4", cyc - acc_q[0], R4);
            seen = 1'b1;
          end
          chk("out_data4", i4.out_data, exp_q[0]);
          if (!i4.out_ready) chk("in_ready_held_low", i4.in_ready, 0);
          else begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (i4.in_valid && i4.in_ready) begin
        exp_q.push_back(model(i4.in_data, i4.in_key, i4.in_decrypt, R4));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // Present one block to the 4-round instance; returns #1 after the accepting edge
  task automatic send4(input logic [BW-1:0] d, input logic [BW-1:0] k, input bit dec);
    bit ok;
    ok = 1'b0;
    i4.in_valid = 1'b1; i4.in_data = d; i4.in_key = k; i4.in_decrypt = dec;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (i4.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", i4.in_ready, 1);
    @(posedge clock); #1;
    i4.in_valid = 1'b0;
  endtask

  task automatic drain4();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clock); #1;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  // One block through the 1-round instance with a literal expectation
  task automatic run1(input logic [BW-1:0] d, input logic [BW-1:0] k, input bit dec,
                      input logic [BW-1:0] exp);
    i1.in_valid = 1'b1; i1.in_data = d; i1.in_key = k; i1.in_decrypt = dec;
    @(negedge clock);
    chk("r1_in_ready", i1.in_ready, 1);
    @(posedge clock); #1;
    i1.in_valid = 1'b0;
    chk("r1_busy_run", busy1, 1);
    chk("r1_early_valid", i1.out_valid, 0);
    @(posedge clock); #1;
    chk("r1_out_valid", i1.out_valid, 1);
    chk("r1_out_data", i1.out_data, exp);
    chk("r1_busy_done", busy1, 0);
    @(posedge clock); #1;
    chk("r1_consumed", i1.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] p, k, ct, a, b, d0, k0;
    n_cmp = 0; n_bad = 0; cyc = 0; seen = 1'b0;
    i1.in_valid = 0; i1.in_data = '0; i1.in_key = '0; i1.in_decrypt = 0; i1.out_ready = 1;
    i4.in_valid = 0; i4.in_data = '0; i4.in_key = '0; i4.in_decrypt = 0; i4.out_ready = 1;
    reset_n = 1'b0;
    #1;
    chk("rst_out_valid", i4.out_valid, 0);
    chk("rst_out_data", i4.out_data, 0);
    chk("rst_busy", busy4, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("idle_in_ready", i4.in_ready, 1);
    @(posedge clock); #1;

    // Model pinned by hand-computed vectors
    chk("pin_enc_k0", model(8'h12, 8'h00, 0, 1), 8'h92);
    chk("pin_enc_k1", model(8'h12, 8'h01, 0, 1), 8'hB2);
    chk("pin_dec_k1", model(8'hB2, 8'h01, 1, 1), 8'h12);

    // Single-round instance, literal expectations
    run1(8'h12, 8'h00, 0, 8'h92);
    run1(8'h12, 8'h01, 0, 8'hB2);
    run1(8'hB2, 8'h01, 1, 8'h12);

    // Random encrypt/decrypt round trips, back to back
    for (int i = 0; i < 200; i++) begin
      p  = BW'($urandom);
      k  = BW'($urandom);
      ct = model(p, k, 0, R4);
      chk("roundtrip_model", model(ct, k, 1, R4), p);
      send4(p, k, 0);
      send4(ct, k, 1);
    end
    drain4();

    // Backpressure: hold result, then release together with a new block
    a = 8'h5A; b = 8'hC3; k = 8'h9E;
    i4.out_ready = 1'b0;
    send4(a, k, 0);
    for (int n = 0; n < 20 && !i4.out_valid; n++) begin @(posedge clock); #1; end
    chk("bp_valid_seen", i4.out_valid, 1);
    repeat (10) begin @(posedge clock); #1; end
    chk("bp_still_valid", i4.out_valid, 1);
    chk("bp_data_held", i4.out_data, model(a, k, 0, R4));
    i4.in_valid = 1'b1; i4.in_data = b; i4.in_key = k; i4.in_decrypt = 1'b0;
    i4.out_ready = 1'b1;
    @(negedge clock);
    chk("b2b_in_ready", i4.in_ready, 1);
    @(posedge clock); #1;
    i4.in_valid = 1'b0;
    chk("b2b_no_idle", busy4, 1);
    chk("b2b_valid_drop", i4.out_valid, 0);
    drain4();

    // Inputs wiggle during RUN; result must reflect captured values
    d0 = 8'h3C; k0 = 8'h71;
    send4(d0, k0, 0);
    for (int n = 0; n < 4; n++) begin
      i4.in_data = BW'($urandom); i4.in_key = BW'($urandom); i4.in_decrypt = ~i4.in_decrypt;
      @(posedge clock); #1;
    end
    i4.in_decrypt = 1'b0;
    drain4();

    // Asynchronous reset in the middle of round processing
    send4(8'hA7, 8'h2D, 0);
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", i4.out_valid, 0);
    chk("mid_rst_out_data", i4.out_data, 0);
    chk("mid_rst_busy", busy4, 0);
    exp_q.delete(); acc_q.delete(); seen = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", i4.in_ready, 1);
    repeat (8) @(posedge clock);
    #1;
    chk("post_rst_no_stale", i4.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
